// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between instruction
// fetch and data access. Data wins by default; a saturating starvation
// counter forces a fetch grant after STARVE_LIMIT consecutive data grants.
// An aborted in-flight fetch is drained on the bus and its word discarded.
module mem_port_arbiter #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   input  logic                  if_abort,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_done,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [3:0]            dm_sel,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  dm_done,
   output logic                  ext_req,
   output logic                  ext_we,
   output logic [3:0]            ext_sel,
   output logic [ADDR_WIDTH-1:0] ext_addr,
   output logic [DATA_WIDTH-1:0] ext_wdata,
   input  logic                  ext_ack,
   input  logic [DATA_WIDTH-1:0] ext_rdata,
   output logic                  busy
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE,
      GRANT_IF,
      GRANT_DM,
      DRAIN
   } state_t;

   state_t     state;
   state_t     state_nx;
   logic [3:0] starve_cnt;
   logic       if_eff;
   logic       grant_if;
   logic       grant_dm;

   // A flushed fetch never competes for the bus.
   assign if_eff  = if_req & ~if_abort;

   // The bus request is exactly "a grant or drain is outstanding"; since the
   // FSM leaves those states on ack, this also drops ext_req after ack and
   // asynchronously on reset.
   assign ext_req = (state != IDLE);
   assign busy    = (state != IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Arbitration and next-state logic.
   always_comb begin
      state_nx = state;
      grant_if = 1'b0;
      grant_dm = 1'b0;
      case (state)
         IDLE: begin
            if (starve_cnt == LIMIT && if_eff) begin
               state_nx = GRANT_IF;
               grant_if = 1'b1;
            end else if (dm_req) begin
               state_nx = GRANT_DM;
               grant_dm = 1'b1;
            end else if (if_eff) begin
               state_nx = GRANT_IF;
               grant_if = 1'b1;
            end
         end
         GRANT_IF: begin
            if (ext_ack)       state_nx = IDLE;
            else if (if_abort) state_nx = DRAIN;
         end
         GRANT_DM, DRAIN: begin
            if (ext_ack) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Latch the winner's bus fields on grant; register completion pulses and read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_we    <= 1'b0;
         ext_sel   <= '0;
         ext_addr  <= '0;
         ext_wdata <= '0;
         if_done   <= 1'b0;
         if_rdata  <= '0;
         dm_done   <= 1'b0;
         dm_rdata  <= '0;
      end else begin
         if_done <= 1'b0;
         dm_done <= 1'b0;
         if (grant_if) begin
            ext_we    <= 1'b0;
            ext_sel   <= 4'hF;
            ext_addr  <= if_addr;
            ext_wdata <= '0;
         end else if (grant_dm) begin
            ext_we    <= dm_we;
            ext_sel   <= dm_sel;
            ext_addr  <= dm_addr;
            ext_wdata <= dm_wdata;
         end
         if (ext_ack) begin
            case (state)
               GRANT_IF: begin
                  if (!if_abort) begin
                     if_done  <= 1'b1;
                     if_rdata <= ext_rdata;
                  end
               end
               GRANT_DM: begin
                  dm_done  <= 1'b1;
                  dm_rdata <= ext_rdata;
               end
               default: ;
            endcase
         end
      end
   end

   // Count data grants taken while a fetch waits; saturates at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (grant_if) begin
         starve_cnt <= '0;
      end else if (grant_dm && if_eff) begin
         if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
      end else if (state == IDLE && !if_eff) begin
         starve_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table for the
// basic transactions, then hand sequences for starvation, abort and reset.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_abort, if_done;
   logic [31:0] if_addr, if_rdata;
   logic        dm_req, dm_we, dm_done;
   logic [3:0]  dm_sel;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        ext_req, ext_we, ext_ack, busy;
   logic [3:0]  ext_sel;
   logic [31:0] ext_addr, ext_wdata, ext_rdata;

   always #5 clk = ~clk;

   mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
      .if_rdata(if_rdata), .if_done(if_done),
      .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done),
      .ext_req(ext_req), .ext_we(ext_we), .ext_sel(ext_sel), .ext_addr(ext_addr),
      .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata), .busy(busy)
   );

   typedef struct packed {
      logic        if_req;
      logic        if_abort;
      logic [31:0] if_addr;
      logic        dm_req;
      logic        dm_we;
      logic [3:0]  dm_sel;
      logic [31:0] dm_addr;
      logic [31:0] dm_wdata;
      logic        ext_ack;
      logic [31:0] ext_rdata;
   } in_t;

   typedef struct packed {
      logic        ext_req;
      logic        ext_we;
      logic [3:0]  ext_sel;
      logic [31:0] ext_addr;
      logic [31:0] ext_wdata;
      logic        if_done;
      logic [31:0] if_rdata;
      logic        dm_done;
      logic [31:0] dm_rdata;
      logic        busy;
   } out_t;

   typedef struct packed {
      in_t  in;
      out_t exp;
   } vec_t;

   out_t cur;
   always_comb begin
      cur = '0;
      cur.ext_req   = ext_req;
      cur.ext_we    = ext_we;
      cur.ext_sel   = ext_sel;
      cur.ext_addr  = ext_addr;
      cur.ext_wdata = ext_wdata;
      cur.if_done   = if_done;
      cur.if_rdata  = if_rdata;
      cur.dm_done   = dm_done;
      cur.dm_rdata  = dm_rdata;
      cur.busy      = busy;
   end

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   function automatic in_t mi(logic ir, logic ab, logic [31:0] ia, logic dr, logic we,
                              logic [3:0] sel, logic [31:0] da, logic [31:0] wd,
                              logic ack, logic [31:0] rd);
      in_t v;
      v.if_req = ir; v.if_abort = ab; v.if_addr = ia;
      v.dm_req = dr; v.dm_we = we; v.dm_sel = sel; v.dm_addr = da; v.dm_wdata = wd;
      v.ext_ack = ack; v.ext_rdata = rd;
      return v;
   endfunction

   function automatic out_t mo(logic rq, logic we, logic [3:0] sel, logic [31:0] ad,
                               logic [31:0] wd, logic ifd, logic [31:0] ifr,
                               logic dmd, logic [31:0] dmr, logic bz);
      out_t v;
      v.ext_req = rq; v.ext_we = we; v.ext_sel = sel; v.ext_addr = ad; v.ext_wdata = wd;
      v.if_done = ifd; v.if_rdata = ifr; v.dm_done = dmd; v.dm_rdata = dmr; v.busy = bz;
      return v;
   endfunction

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input in_t v);
      if_req = v.if_req; if_abort = v.if_abort; if_addr = v.if_addr;
      dm_req = v.dm_req; dm_we = v.dm_we; dm_sel = v.dm_sel;
      dm_addr = v.dm_addr; dm_wdata = v.dm_wdata;
      ext_ack = v.ext_ack; ext_rdata = v.ext_rdata;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t        tbl[16];
   logic [31:0] st_addr[6];

   initial begin
      // Each row: inputs held during a cycle, outputs expected in the next cycle.
      tbl[0]  = '{mi(1,0,32'h0040_0000,0,0,4'h0,0,0,0,0),
                  mo(1,0,4'hF,32'h0040_0000,0,0,0,0,0,1)};
      tbl[1]  = tbl[0];
      tbl[2]  = tbl[0];
      tbl[3]  = '{mi(1,0,32'h0040_0000,0,0,4'h0,0,0,1,32'h2008_0005),
                  mo(0,0,4'hF,32'h0040_0000,0,1,32'h2008_0005,0,0,0)};
      tbl[4]  = '{mi(0,0,0,0,0,4'h0,0,0,0,0),
                  mo(0,0,4'hF,32'h0040_0000,0,0,32'h2008_0005,0,0,0)};
      tbl[5]  = '{mi(1,0,32'h100,1,0,4'hF,32'h8000,0,0,0),
                  mo(1,0,4'hF,32'h8000,0,0,32'h2008_0005,0,0,1)};
      tbl[6]  = '{mi(1,0,32'h100,1,0,4'hF,32'h8000,0,1,32'h1111_1111),
                  mo(0,0,4'hF,32'h8000,0,0,32'h2008_0005,1,32'h1111_1111,0)};
      tbl[7]  = '{mi(1,0,32'h100,0,0,4'h0,0,0,0,0),
                  mo(1,0,4'hF,32'h100,0,0,32'h2008_0005,0,32'h1111_1111,1)};
      tbl[8]  = '{mi(1,0,32'h100,0,0,4'h0,0,0,1,32'h2222_2222),
                  mo(0,0,4'hF,32'h100,0,1,32'h2222_2222,0,32'h1111_1111,0)};
      tbl[9]  = '{mi(0,0,0,0,0,4'h0,0,0,0,0),
                  mo(0,0,4'hF,32'h100,0,0,32'h2222_2222,0,32'h1111_1111,0)};
      tbl[10] = '{mi(0,0,0,1,1,4'h3,32'h10,32'hDEAD_BEEF,0,0),
                  mo(1,1,4'h3,32'h10,32'hDEAD_BEEF,0,32'h2222_2222,0,32'h1111_1111,1)};
      tbl[11] = '{mi(0,0,0,1,0,4'hC,32'h20,32'h0,0,0),
                  mo(1,1,4'h3,32'h10,32'hDEAD_BEEF,0,32'h2222_2222,0,32'h1111_1111,1)};
      tbl[12] = '{mi(0,0,0,1,1,4'h3,32'h10,32'hDEAD_BEEF,1,32'h1111_1111),
                  mo(0,1,4'h3,32'h10,32'hDEAD_BEEF,0,32'h2222_2222,1,32'h1111_1111,0)};
      tbl[13] = '{mi(0,0,0,0,0,4'h0,0,0,0,0),
                  mo(0,1,4'h3,32'h10,32'hDEAD_BEEF,0,32'h2222_2222,0,32'h1111_1111,0)};
      tbl[14] = '{mi(1,1,32'h500,0,0,4'h0,0,0,0,0),
                  mo(0,1,4'h3,32'h10,32'hDEAD_BEEF,0,32'h2222_2222,0,32'h1111_1111,0)};
      tbl[15] = tbl[13];

      st_addr[0] = 32'h40; st_addr[1] = 32'h40; st_addr[2] = 32'h40;
      st_addr[3] = 32'h40; st_addr[4] = 32'h200; st_addr[5] = 32'h40;

      rst_n = 1'b0;
      apply(tbl[13].in);
      step();
      chk("reset_outputs", 160'(cur), 160'(0));
      chk("reset_starve", 160'(dut.starve_cnt), 160'(0));
      @(negedge clk);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 16; i++) begin
         apply(tbl[i].in);
         step();
         chk($sformatf("row%0d", i), 160'(cur), 160'(tbl[i].exp));
         if (i == 5) chk("starve_after_dm", 160'(dut.starve_cnt), 160'(1));
      end

      // Starvation: both requests held; expect four data grants, one fetch, then data.
      if_req = 1; if_abort = 0; if_addr = 32'h200;
      dm_req = 1; dm_we = 0; dm_sel = 4'hF; dm_addr = 32'h40; dm_wdata = 0;
      for (int k = 0; k < 6; k++) begin
         int unsigned w;
         w = 0;
         step();
         while (!ext_req && w < 20) begin
            step();
            w++;
         end
         chk($sformatf("starve_req%0d", k), 160'(ext_req), 160'(1));
         chk($sformatf("starve_addr%0d", k), 160'(ext_addr), 160'(st_addr[k]));
         ext_ack = 1; ext_rdata = 32'(k);
         step();
         ext_ack = 0;
         chk($sformatf("starve_done%0d", k), 160'({if_done, dm_done}),
             160'((k == 4) ? 2'b10 : 2'b01));
      end
      if_req = 0; dm_req = 0;
      step();
      step();

      // Abort while the fetch is in flight; data waits behind the drain.
      if_req = 1; if_addr = 32'h300;
      step();
      chk("abort_grant", 160'({ext_req, ext_addr}), 160'({1'b1, 32'h300}));
      if_abort = 1; dm_req = 1; dm_we = 0; dm_addr = 32'h50; dm_sel = 4'hF;
      step();
      if_abort = 0; if_req = 0;
      chk("drain_c2", 160'({ext_req, busy, if_done}), 160'(3'b110));
      step();
      chk("drain_c3", 160'({ext_req, busy, if_done}), 160'(3'b110));
      ext_ack = 1; ext_rdata = 32'h9999_9999;
      step();
      ext_ack = 0;
      chk("drain_end", 160'({ext_req, if_done, dm_done}), 160'(3'b000));
      step();
      chk("after_drain_dm", 160'({ext_req, ext_addr}), 160'({1'b1, 32'h50}));
      ext_ack = 1; ext_rdata = 32'h0000_ABCD;
      step();
      ext_ack = 0; dm_req = 0;
      chk("after_drain_done", 160'({dm_done, if_done, dm_rdata}), 160'({2'b10, 32'h0000_ABCD}));
      step();

      // Abort coincident with ack: word dropped, straight back to IDLE.
      if_req = 1; if_addr = 32'h400;
      step();
      chk("coinc_grant", 160'({ext_req, ext_addr}), 160'({1'b1, 32'h400}));
      ext_ack = 1; if_abort = 1; ext_rdata = 32'h5555_5555;
      step();
      ext_ack = 0; if_abort = 0; if_req = 0;
      chk("coinc_end", 160'({if_done, busy, ext_req}), 160'(3'b000));
      step();
      chk("coinc_quiet", 160'({if_done, busy}), 160'(2'b00));

      // Reset in the middle of a write, then a fresh write completes.
      dm_req = 1; dm_we = 1; dm_sel = 4'b0011; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF;
      step();
      chk("rst_write_grant", 160'({ext_req, ext_we, ext_sel, ext_wdata}),
          160'({2'b11, 4'b0011, 32'hDEAD_BEEF}));
      #2 rst_n = 0;
      #1;
      chk("rst_async_outputs", 160'(cur), 160'(0));
      @(negedge clk);
      rst_n = 1;
      step();
      chk("rst_regrant", 160'({ext_req, ext_we, ext_sel, ext_addr, ext_wdata}),
          160'({2'b11, 4'b0011, 32'h10, 32'hDEAD_BEEF}));
      ext_ack = 1;
      step();
      ext_ack = 0; dm_req = 0;
      chk("rst_write_done", 160'({dm_done, if_done, ext_req}), 160'(3'b100));
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
